// File: rtl/ef_tcc32_sched.sv
// ef_tcc32_sched: shares one EF_TCC32 one-shot timer among NREQ requesters.
// Requests are granted round-robin. Each grant runs an APB write sequence that
// arms the timer, waits for it to expire, then clears and stops it before
// pulsing done for the owner.
// Build macro EF_TCC32_SCHED_IRQ_EN: unmasks the timeout interrupt and waits on
// irq instead of polling RIS over the bus.
module ef_tcc32_sched #(
  parameter int unsigned NREQ             = 4,
  parameter logic [31:0] CONTROL_REG_ADDR = 32'h08,
  parameter logic [31:0] PERIOD_REG_ADDR  = 32'h04,
  parameter logic [31:0] RIS_REG_ADDR     = 32'hFF08,
  parameter logic [31:0] IM_REG_ADDR      = 32'hFF00,
  parameter logic [31:0] ICR_REG_ADDR     = 32'hFF0C,
  parameter logic [31:0] CTRL_GO          = 32'h0000_000B
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   period,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [31:0]          PADDR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 irq
);

  localparam int unsigned     IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    W_OFF,
    W_PER,
    W_CLR,
`ifdef EF_TCC32_SCHED_IRQ_EN
    W_IM,
`endif
    W_GO,
    WAIT_TO,
    W_ACK,
    W_STOP,
    DONE
  } state_t;

  // Position inside the current APB transfer; PH_IDLE doubles as the
  // mandatory bus-idle gap between consecutive transfers.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

  state_t          state;
  state_t          after;
  phase_t          phase;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   cand_idx;
  logic            arb_hit;
  logic [NREQ-1:0] arb_oh;
  logic [31:0]     arb_per;
  logic [31:0]     per_q;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_data;
  logic            bus_write;
  logic            is_bus;
  int unsigned     cand;
  logic [31:0]     per_arr [NREQ];
  logic            unused_inputs;

`ifdef EF_TCC32_SCHED_IRQ_EN
  assign unused_inputs = ^PRDATA;
`else
  assign unused_inputs = ^{PRDATA[31:1], irq};
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign per_arr[g] = period[32*g +: 32];
  end

  // Round-robin search: first active request at or after rr_ptr, wrapping.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_oh   = '0;
    arb_per  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = cand[IW-1:0];
      if (!arb_hit && req[cand_idx]) begin
        arb_hit          = 1'b1;
        arb_idx          = cand_idx;
        arb_oh[cand_idx] = 1'b1;
        arb_per          = per_arr[cand_idx];
      end
    end
  end

  // Per-state APB transfer contents and the state reached once it completes.
  always_comb begin
    is_bus    = 1'b1;
    bus_addr  = '0;
    bus_data  = '0;
    bus_write = 1'b1;
    after     = IDLE;
    case (state)
      W_OFF: begin
        bus_addr = CONTROL_REG_ADDR;
        after    = W_PER;
      end
      W_PER: begin
        bus_addr = PERIOD_REG_ADDR;
        bus_data = per_q;
        after    = W_CLR;
      end
      W_CLR: begin
        bus_addr = ICR_REG_ADDR;
        bus_data = 32'h7;
`ifdef EF_TCC32_SCHED_IRQ_EN
        after    = W_IM;
`else
        after    = W_GO;
`endif
      end
`ifdef EF_TCC32_SCHED_IRQ_EN
      W_IM: begin
        bus_addr = IM_REG_ADDR;
        bus_data = 32'h1;
        after    = W_GO;
      end
`endif
      W_GO: begin
        bus_addr = CONTROL_REG_ADDR;
        bus_data = CTRL_GO;
        after    = WAIT_TO;
      end
      WAIT_TO: begin
`ifdef EF_TCC32_SCHED_IRQ_EN
        is_bus    = 1'b0;
`else
        bus_addr  = RIS_REG_ADDR;
        bus_write = 1'b0;
`endif
        after     = W_ACK;
      end
      W_ACK: begin
        bus_addr = ICR_REG_ADDR;
        bus_data = 32'h1;
        after    = W_STOP;
      end
      W_STOP: begin
        bus_addr = CONTROL_REG_ADDR;
        after    = DONE;
      end
      default: begin
        is_bus = 1'b0;
      end
    endcase
  end

  // Scheduler FSM with registered grant/done/busy and APB master outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      phase   <= PH_IDLE;
      rr_ptr  <= '0;
      per_q   <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (arb_hit) begin
            grant  <= arb_oh;
            busy   <= 1'b1;
            per_q  <= arb_per;
            rr_ptr <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            state  <= (arb_per == '0) ? DONE : W_OFF;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          done  <= grant;
          grant <= '0;
          busy  <= 1'b0;
          phase <= PH_IDLE;
          state <= IDLE;
        end
        default: begin
          if (is_bus) begin
            case (phase)
              PH_IDLE: begin
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PADDR   <= bus_addr;
                PWDATA  <= bus_data;
                PWRITE  <= bus_write;
                phase   <= PH_SETUP;
              end
              PH_SETUP: begin
                PENABLE <= 1'b1;
                phase   <= PH_ACCESS;
              end
              PH_ACCESS: begin
                if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  phase   <= PH_IDLE;
`ifdef EF_TCC32_SCHED_IRQ_EN
                  state   <= after;
`else
                  // A RIS read that still shows no timeout re-polls from the same state.
                  if (state != WAIT_TO || PRDATA[0]) begin
                    state <= after;
                  end
`endif
                end
              end
              default: begin
                phase <= PH_IDLE;
              end
            endcase
`ifdef EF_TCC32_SCHED_IRQ_EN
          end else if (irq) begin
            state <= after;
          end
`else
          end else begin
            state <= IDLE;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ef_tcc32_sched.sv
// tb_ef_tcc32_sched: drives ef_tcc32_sched against a behavioural EF_TCC32 APB
// slave (register file plus one-shot down-counter) and checks the transfer log,
// grant/done order and bus protocol against the expected scheduling rules.
module tb_ef_tcc32_sched;

  localparam int unsigned NREQ   = 4;
  localparam logic [31:0] A_CTRL = 32'h08;
  localparam logic [31:0] A_PER  = 32'h04;
  localparam logic [31:0] A_RIS  = 32'hFF08;
  localparam logic [31:0] A_IM   = 32'hFF00;
  localparam logic [31:0] A_ICR  = 32'hFF0C;
  localparam logic [31:0] GO     = 32'h0000_000B;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   period;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [31:0]          PADDR;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 irq;

  always #5 PCLK = ~PCLK;

  ef_tcc32_sched #(
    .NREQ             (NREQ),
    .CONTROL_REG_ADDR (A_CTRL),
    .PERIOD_REG_ADDR  (A_PER),
    .RIS_REG_ADDR     (A_RIS),
    .IM_REG_ADDR      (A_IM),
    .ICR_REG_ADDR     (A_ICR),
    .CTRL_GO          (GO)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (req),
    .period  (period),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .irq     (irq)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        stable;
  } xfer_t;

  xfer_t       xlog [$];
  int unsigned glog [$];
  int unsigned dlog [$];

  int          total = 0;
  int          bad = 0;
  int          proto_bad = 0;
  int          psel_cyc = 0;
  int          ws_mode = -1;
  logic        irq_force = 1'b0;
  int unsigned rr = 0;

  // slave / monitor state
  logic [31:0] reg_per, ris, im, cap_addr, cap_data;
  logic        cap_wr, cap_stable, running, prev_cmpl, prev_done;
  logic [NREQ-1:0] prev_grant;
  int          cnt, wcnt;

  function automatic int unsigned oh_idx(input logic [NREQ-1:0] v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Behavioural EF_TCC32 slave plus protocol monitor, evaluated on the falling edge.
  initial begin
    xfer_t x;
    PREADY = 1'b0; PRDATA = '0; irq = 1'b0;
    reg_per = '0; ris = '0; im = '0; running = 1'b0; cnt = 0; wcnt = 0;
    cap_addr = '0; cap_data = '0; cap_wr = 1'b0; cap_stable = 1'b0;
    prev_cmpl = 1'b0; prev_done = 1'b0; prev_grant = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        reg_per = '0; ris = '0; im = '0; running = 1'b0; cnt = 0; wcnt = 0;
        prev_cmpl = 1'b0; prev_done = 1'b0; prev_grant = '0;
        PREADY = 1'b0; PRDATA = '0; irq = irq_force;
      end else begin
        if (running) begin
          if (cnt <= 1) begin ris[0] = 1'b1; running = 1'b0; end
          else cnt = cnt - 1;
        end
        if (PSEL) psel_cyc++;
        if (PENABLE && !PSEL) proto_bad++;
        if (prev_cmpl && PSEL) proto_bad++;
        prev_cmpl = 1'b0;
        if ($countones(grant) > 1) proto_bad++;
        if (busy !== (|grant)) proto_bad++;
        if (done != '0) begin
          if ($countones(done) != 1 || prev_done) proto_bad++;
          dlog.push_back(oh_idx(done));
        end
        prev_done = |done;
        if (grant != '0 && prev_grant == '0) glog.push_back(oh_idx(grant));
        prev_grant = grant;
        PREADY = 1'b0;
        PRDATA = '0;
        if (PSEL && !PENABLE) begin
          cap_addr = PADDR; cap_data = PWDATA; cap_wr = PWRITE; cap_stable = 1'b1;
          wcnt = (ws_mode < 0) ? int'($urandom_range(0, 2)) : ws_mode;
        end else if (PSEL && PENABLE) begin
          if (PADDR !== cap_addr || PWDATA !== cap_data || PWRITE !== cap_wr) cap_stable = 1'b0;
          if (wcnt > 0) begin
            wcnt = wcnt - 1;
          end else begin
            PREADY = 1'b1;
            prev_cmpl = 1'b1;
            x.addr = cap_addr; x.wr = cap_wr; x.stable = cap_stable;
            if (cap_wr) begin
              x.data = cap_data;
              if (cap_addr == A_CTRL) begin
                if (cap_data == GO) begin
                  cnt = int'(reg_per);
                  running = (reg_per != 0);
                  if (reg_per == 0) ris[0] = 1'b1;
                end else running = 1'b0;
              end else if (cap_addr == A_PER) reg_per = cap_data;
              else if (cap_addr == A_ICR) ris = ris & ~cap_data;
              else if (cap_addr == A_IM)  im = cap_data;
            end else begin
              PRDATA = (cap_addr == A_RIS) ? ris : '0;
              x.data = PRDATA;
            end
            xlog.push_back(x);
          end
        end
        irq = irq_force | (|(ris & im));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_w(input string tag, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    chk({tag, "_present"}, 96'(xlog.size() != 0), 96'd1);
    if (xlog.size() == 0) return;
    x = xlog.pop_front();
    chk(tag, {x.wr, x.stable, x.addr, x.data}, {1'b1, 1'b1, a, d});
  endtask

  // Expected APB traffic for one granted delay, from the timer programming recipe.
  task automatic check_job(input string tag, input logic [31:0] p);
    xfer_t x;
    int unsigned nrd, nbad, nset;
    logic last;
    if (p == 0) return;
    exp_w({tag, "_off"}, A_CTRL, 32'h0);
    exp_w({tag, "_per"}, A_PER, p);
    exp_w({tag, "_clr"}, A_ICR, 32'h7);
`ifdef EF_TCC32_SCHED_IRQ_EN
    exp_w({tag, "_im"}, A_IM, 32'h1);
`endif
    exp_w({tag, "_go"}, A_CTRL, GO);
    nrd = 0; nbad = 0; nset = 0; last = 1'b0;
    while (xlog.size() != 0 && !xlog[0].wr) begin
      x = xlog.pop_front();
      nrd++;
      if (x.addr !== A_RIS || !x.stable) nbad++;
      if (x.data[0]) nset++;
      last = x.data[0];
    end
`ifdef EF_TCC32_SCHED_IRQ_EN
    chk({tag, "_reads"}, 96'(nrd), 96'd0);
`else
    chk({tag, "_polls"}, {32'(nbad), 32'(nset), 31'(nrd != 0), last}, {32'd0, 32'd1, 31'd1, 1'b1});
`endif
    exp_w({tag, "_ack"}, A_ICR, 32'h1);
    exp_w({tag, "_stop"}, A_CTRL, 32'h0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_grant"},   96'(grant),   96'd0);
    chk({tag, "_done"},    96'(done),    96'd0);
    chk({tag, "_busy"},    96'(busy),    96'd0);
    chk({tag, "_psel"},    96'(PSEL),    96'd0);
    chk({tag, "_penable"}, 96'(PENABLE), 96'd0);
    chk({tag, "_pwrite"},  96'(PWRITE),  96'd0);
    chk({tag, "_paddr"},   96'(PADDR),   96'd0);
    chk({tag, "_pwdata"},  96'(PWDATA),  96'd0);
  endtask

  // Raise a set of requests together; each requester drops on its own done.
  task automatic run_batch(input string tag, input logic [NREQ-1:0] mask,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3);
    logic [31:0] pers [NREQ];
    int unsigned order [$];
    int unsigned cyc;
    pers[0] = p0; pers[1] = p1; pers[2] = p2; pers[3] = p3;
    period = {p3, p2, p1, p0};
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (rr + k) % NREQ;
      if (mask[idx]) order.push_back(idx);
    end
    xlog.delete(); glog.delete(); dlog.delete();
    req = mask;
    cyc = 0;
    while (req != '0 && cyc < 4000) begin
      @(negedge PCLK);
      cyc++;
      req = req & ~done;
    end
    chk({tag, "_in_time"}, 96'(cyc < 4000), 96'd1);
    req = '0;
    repeat (3) @(negedge PCLK);
    chk({tag, "_busy_after"}, 96'(busy), 96'd0);
    chk({tag, "_ngrant"}, 96'(glog.size()), 96'(order.size()));
    chk({tag, "_ndone"},  96'(dlog.size()), 96'(order.size()));
    for (int unsigned k = 0; k < order.size(); k++) begin
      if (k < glog.size()) chk($sformatf("%s_grant%0d", tag, k), 96'(glog[k]), 96'(order[k]));
      if (k < dlog.size()) chk($sformatf("%s_done%0d", tag, k), 96'(dlog[k]), 96'(order[k]));
    end
    for (int unsigned k = 0; k < order.size(); k++)
      check_job($sformatf("%s_job%0d", tag, k), pers[order[k]]);
    chk({tag, "_extra_xfers"}, 96'(xlog.size()), 96'd0);
    if (order.size() != 0) rr = (order[order.size()-1] + 1) % NREQ;
  endtask

  function automatic logic go_seen();
    logic r;
    r = 1'b0;
    foreach (xlog[i]) if (xlog[i].wr && xlog[i].addr == A_CTRL && xlog[i].data == GO) r = 1'b1;
    return r;
  endfunction

  initial begin
    int unsigned cyc, n2, pc0;
    logic [NREQ-1:0] m;
    PRESETn = 1'b0; req = '0; period = '0;
    repeat (3) @(negedge PCLK);
    chk_zero_outs("reset");
    PRESETn = 1'b1;
    rr = 0;
    @(negedge PCLK);

    // single requester, full write/poll/ack sequence
    run_batch("single", 4'b0001, 32'd20, 32'd0, 32'd0, 32'd0);

    // all four at once: round-robin from pointer 1
    run_batch("all4", 4'b1111, 32'd5, 32'd10, 32'd15, 32'd20);

    // zero period: done quickly, bus untouched
    period = {32'd0, 32'd0, 32'd0, 32'd0};
    pc0 = psel_cyc;
    dlog.delete();
    req = 4'b0010;
    cyc = 0;
    while (!done[1] && cyc < 20) begin
      @(negedge PCLK);
      cyc++;
    end
    chk("zero_latency", 96'(cyc <= 3), 96'd1);
    req = '0;
    repeat (3) @(negedge PCLK);
    chk("zero_ndone", 96'(dlog.size()), 96'd1);
    chk("zero_no_psel", 96'(psel_cyc - pc0), 96'd0);
    rr = 2;

    // requester 2 holds its request across its own done while 1 arrives
    period = {32'd0, 32'd30, 32'd8, 32'd0};
    xlog.delete(); glog.delete(); dlog.delete();
    req = 4'b0100;
    repeat (6) @(negedge PCLK);
    req[1] = 1'b1;
    n2 = 0; cyc = 0;
    while (req != '0 && cyc < 4000) begin
      @(negedge PCLK);
      cyc++;
      if (done[1]) req[1] = 1'b0;
      if (done[2]) begin
        n2++;
        if (n2 == 2) req[2] = 1'b0;
      end
    end
    chk("hold_in_time", 96'(cyc < 4000), 96'd1);
    req = '0;
    repeat (3) @(negedge PCLK);
    chk("hold_ngrant", 96'(glog.size()), 96'd3);
    if (glog.size() == 3) chk("hold_order", {32'(glog[0]), 32'(glog[1]), 32'(glog[2])}, {32'd2, 32'd1, 32'd2});
    check_job("hold_a", 32'd30);
    check_job("hold_b", 32'd8);
    check_job("hold_c", 32'd30);
    rr = 3;

    // randomized request sets, periods and wait states
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(1, 15));
`ifndef EF_TCC32_SCHED_IRQ_EN
      irq_force = r[0];
`endif
      run_batch($sformatf("rnd%0d", r), m, 32'($urandom_range(0, 25)), 32'($urandom_range(0, 25)),
                32'($urandom_range(0, 25)), 32'($urandom_range(0, 25)));
    end
    irq_force = 1'b0;

    // every transfer stretched by three wait states
    ws_mode = 3;
    run_batch("ws3", 4'b0101, 32'd12, 32'd0, 32'd7, 32'd0);
    ws_mode = -1;

    // reset while waiting for the timeout
    period = {32'd0, 32'd60, 32'd0, 32'd0};
    xlog.delete(); glog.delete(); dlog.delete();
    req = 4'b0100;
    cyc = 0;
    while (!go_seen() && cyc < 600) begin
      @(negedge PCLK);
      cyc++;
    end
    chk("mid_go_seen", 96'(go_seen()), 96'd1);
    repeat (4) @(negedge PCLK);
    chk("mid_no_done", 96'(dlog.size()), 96'd0);
    PRESETn = 1'b0;
    req = '0;
    #1;
    chk_zero_outs("mid_reset");
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    rr = 0;
    @(negedge PCLK);
    run_batch("after_rst", 4'b1001, 32'd6, 32'd0, 32'd0, 32'd9);

    chk("protocol", 96'(proto_bad), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
